// File: rtl/nf_board_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nf_board_pkg
//  Description : Shared board-level constants for the nanoFOX board tops.
//                NF_DB_10MS  - debounce window of 10 ms at a 50 MHz clock.
//                NF_KEY_RST  - idle/reset level of the active-low keys.
//  Revision    : 1.0 - initial release
// ============================================================================
package nf_board_pkg;

    localparam int   NF_DB_10MS = 500000;
    localparam logic NF_KEY_RST = 1'b1;

endpackage : nf_board_pkg
`default_nettype wire

// File: rtl/nf_debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module      : nf_debounce_bit
//  Description : One input channel: two-flop synchronizer, stability
//                counter, debounced level flop and registered edge pulses.
//  Ports       : clk      - system clock
//                resetn   - synchronous reset, active-low
//                raw_in   - asynchronous pin level
//                stable   - debounced level
//                rise     - one-cycle pulse, stable went 0->1
//                fall     - one-cycle pulse, stable went 1->0
//                rise_nxt - value rise takes at the next edge
//                fall_nxt - value fall takes at the next edge
//  Revision    : 1.0 - initial release
// ============================================================================
module nf_debounce_bit
    import nf_board_pkg::*;
#(
    parameter int   DB_CYCLES = NF_DB_10MS,
    parameter logic RST_VAL   = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw_in,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic rise_nxt,
    output logic fall_nxt
);

    localparam int                 c_cnt_w = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_term  = c_cnt_w'(DB_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic               r_s1;
    logic               r_s2;
    logic               r_stable;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_rise;
    logic               r_fall;

    logic               w_differ;
    logic               w_term;
    logic               w_flip;

    assign w_differ = r_s2 ^ r_stable;
    assign w_term   = (r_cnt == c_term);
    // The new level is accepted on the edge that would take the counter
    // past the terminal count; the counter itself never exceeds c_term.
    assign w_flip   = w_differ & w_term;

    assign rise_nxt = w_flip &  r_s2;
    assign fall_nxt = w_flip & ~r_s2;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_s1     <= RST_VAL;
            r_s2     <= RST_VAL;
            r_stable <= RST_VAL;
            r_cnt    <= '0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_s1 <= raw_in;
            r_s2 <= r_s1;
            // Any return to the accepted level restarts the whole window.
            if (!w_differ || w_term) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_one;
            end
            if (w_flip) begin
                r_stable <= r_s2;
            end
            r_rise <= rise_nxt;
            r_fall <= fall_nxt;
        end
    end

    assign stable = r_stable;
    assign rise   = r_rise;
    assign fall   = r_fall;

endmodule : nf_debounce_bit
`default_nettype wire

// File: rtl/nf_input_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : nf_input_debounce
//  Description : Board-input conditioner. Synchronizes and debounces WIDTH
//                key/switch pins, produces clean levels, single-cycle edge
//                pulses and a sticky change mask with per-bit acknowledge.
//  Ports       : clk      - system clock
//                resetn   - synchronous reset, active-low
//                raw_in   - asynchronous pin levels
//                stable   - debounced levels
//                rise     - one-cycle pulses on 0->1
//                fall     - one-cycle pulses on 1->0
//                chg_mask - sticky per-channel change record
//                chg_flag - OR of chg_mask
//                chg_ack  - per-bit clear of chg_mask (level-sampled)
//  Revision    : 1.0 - initial release
// ============================================================================
module nf_input_debounce
    import nf_board_pkg::*;
#(
    parameter int               WIDTH     = 10,
    parameter int               DB_CYCLES = NF_DB_10MS,
    parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] chg_mask,
    output logic             chg_flag,
    input  logic [WIDTH-1:0] chg_ack
);

    logic [WIDTH-1:0] w_rise_nxt;
    logic [WIDTH-1:0] w_fall_nxt;
    logic [WIDTH-1:0] r_chg_mask;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
        nf_debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .RST_VAL   (RST_VAL[gi])
        ) u_bit (
            .clk      (clk),
            .resetn   (resetn),
            .raw_in   (raw_in[gi]),
            .stable   (stable[gi]),
            .rise     (rise[gi]),
            .fall     (fall[gi]),
            .rise_nxt (w_rise_nxt[gi]),
            .fall_nxt (w_fall_nxt[gi])
        );
    end

    // The mask bit is set on the same edge the pulse is registered, so an
    // ack arriving in that cycle loses to the new edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_chg_mask <= '0;
        end else begin
            r_chg_mask <= (r_chg_mask & ~chg_ack) | w_rise_nxt | w_fall_nxt;
        end
    end

    assign chg_mask = r_chg_mask;
    assign chg_flag = |r_chg_mask;

endmodule : nf_input_debounce
`default_nettype wire

// File: tb/tb_nf_input_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nf_input_debounce
//  Description : Self-checking bench for nf_input_debounce (WIDTH=4,
//                DB_CYCLES=8, RST_VAL=4'b0001). A window-based reference
//                model accepts a level once the synchronized input has
//                differed from the accepted level for DB_CYCLES consecutive
//                edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nf_input_debounce;

    localparam int         c_w   = 4;
    localparam int         c_db  = 8;
    localparam logic [3:0] c_rst = 4'b0001;

    logic           clk = 1'b0;
    logic           resetn;
    logic [c_w-1:0] raw_in;
    logic [c_w-1:0] chg_ack;
    logic [c_w-1:0] stable;
    logic [c_w-1:0] rise;
    logic [c_w-1:0] fall;
    logic [c_w-1:0] chg_mask;
    logic           chg_flag;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [c_w-1:0] m_s1, m_s2, m_stable, m_rise, m_fall, m_mask;
    logic [c_w-1:0] m_hist[$];

    always #5 clk = ~clk;

    nf_input_debounce #(
        .WIDTH     (c_w),
        .DB_CYCLES (c_db),
        .RST_VAL   (c_rst)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .raw_in   (raw_in),
        .stable   (stable),
        .rise     (rise),
        .fall     (fall),
        .chg_mask (chg_mask),
        .chg_flag (chg_flag),
        .chg_ack  (chg_ack)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs the DUT sampled.
    task automatic model_edge();
        logic [3:0] flip;
        logic [3:0] nxt;
        if (!resetn) begin
            m_s1 = c_rst; m_s2 = c_rst; m_stable = c_rst;
            m_rise = '0; m_fall = '0; m_mask = '0;
            m_hist.delete();
        end else begin
            m_hist.push_back(m_s2);
            if (m_hist.size() > c_db) void'(m_hist.pop_front());
            flip = '0;
            for (int ch = 0; ch < c_w; ch++) begin
                if (m_hist.size() == c_db) begin
                    flip[ch] = 1'b1;
                    foreach (m_hist[k])
                        if (m_hist[k][ch] == m_stable[ch]) flip[ch] = 1'b0;
                end
            end
            nxt      = m_stable ^ flip;
            m_rise   = flip & nxt;
            m_fall   = flip & ~nxt;
            m_mask   = (m_mask & ~chg_ack) | m_rise | m_fall;
            m_stable = nxt;
            m_s2     = m_s1;
            m_s1     = raw_in;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("stable", stable, m_stable);
        check("rise", rise, m_rise);
        check("fall", fall, m_fall);
        check("chg_mask", chg_mask, m_mask);
        check("chg_flag", {3'b000, chg_flag}, {3'b000, |m_mask});
    endtask

    initial begin
        resetn  = 1'b0;
        raw_in  = 4'b0001;
        chg_ack = 4'b0000;
        m_s1 = 'x; m_s2 = 'x; m_stable = 'x; m_rise = 'x; m_fall = 'x; m_mask = 'x;

        // Reset: held low 3 cycles, then released with no pulse.
        repeat (3) tick();
        check("rst_stable", stable, 4'b0001);
        check("rst_mask", chg_mask, 4'b0000);
        resetn = 1'b1;
        repeat (12) tick();
        check("idle_stable", stable, 4'b0001);
        check("idle_flag", {3'b000, chg_flag}, 4'b0000);

        // Clean press on channel 1: capture at E, outputs at E+9.
        raw_in = 4'b0011;
        tick();                       // E
        repeat (8) tick();            // E+8
        check("press_e8_stable", stable, 4'b0001);
        tick();                       // E+9
        check("press_stable", stable, 4'b0011);
        check("press_rise", rise, 4'b0010);
        check("press_mask", chg_mask, 4'b0010);
        check("press_flag", {3'b000, chg_flag}, 4'b0001);
        tick();
        check("press_rise_off", rise, 4'b0000);

        // Bounce on channel 2 (5 high, 2 low, then held), then ack collision.
        raw_in = 4'b0111; repeat (5) tick();
        raw_in = 4'b0011; repeat (2) tick();
        raw_in = 4'b0111;
        tick();                       // final capture E
        repeat (8) tick();            // E+8
        check("bounce_no_rise", rise, 4'b0000);
        chg_ack = 4'b0110;
        tick();                       // E+9: rise[2] collides with ack
        check("bounce_rise", rise, 4'b0100);
        check("collide_mask", chg_mask, 4'b0100);
        chg_ack = 4'b0100;
        tick();
        check("ack_mask", chg_mask, 4'b0000);
        check("ack_flag", {3'b000, chg_flag}, 4'b0000);
        chg_ack = 4'b0000;
        repeat (3) tick();

        // Release on the reset-high channel 0.
        raw_in = 4'b0110;
        tick();                       // E
        repeat (8) tick();
        check("rel_no_fall", fall, 4'b0000);
        tick();                       // E+9
        check("rel_fall", fall, 4'b0001);
        check("rel_stable", stable, 4'b0110);
        check("rel_mask0", {3'b000, chg_mask[0]}, 4'b0001);
        repeat (2) tick();

        // Reset mid-count on channel 3.
        raw_in = 4'b1110;
        repeat (6) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        repeat (9) tick();
        check("midrst_no_rise", {3'b000, rise[3]}, 4'b0000);
        tick();
        check("midrst_rise", {3'b000, rise[3]}, 4'b0001);
        repeat (3) tick();

        // Randomized phase: sporadic toggles give both glitches and
        // accepted changes; random acks and rare resets.
        for (int n = 0; n < 900; n++) begin
            for (int ch = 0; ch < c_w; ch++)
                if ($urandom_range(0, 9) == 0) raw_in[ch] = ~raw_in[ch];
            chg_ack = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'b0000;
            resetn  = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_nf_input_debounce
`default_nettype wire
